cpu_irq_arbiter: RTL and testbench

CPU_IRQ_ARBITER -- requirements
Module: cpu_irq_arbiter

---
 rtl/cpu_irq_arbiter.sv | 144 ++++++++++++++
 tb/tb_cpu_irq_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_irq_arbiter.sv
// External interrupt arbiter: per-source level/edge gateways, priority/threshold
// selection, claim/complete handshake and a small config register file.
module cpu_irq_arbiter #(
  parameter int                     NUM_SOURCES = 8,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK   = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_i,
  input  logic                   claim_i,
  output logic [3:0]             claim_id_o,
  input  logic                   complete_i,
  input  logic [3:0]             complete_id_i,
  input  logic                   cfg_write_enable_i,
  input  logic [1:0]             cfg_addr_i,
  input  logic [31:0]            cfg_data_i,
  input  logic                   cfg_read_enable_i,
  output logic [31:0]            cfg_read_data_o,
  output logic                   interrupt_o
);

  localparam int PW = 3 * NUM_SOURCES;

  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] deferred_q, deferred_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic [NUM_SOURCES-1:0] prev_q, prev_d;
  logic [PW-1:0]          prio_q, prio_d;
  logic [2:0]             threshold_q, threshold_d;
  logic [3:0]             claim_id_q, claim_id_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] rise;
  logic [3:0]             best_id;
  logic [2:0]             best_prio;
  logic                   cfg_data_unused;

  assign cfg_data_unused = ^cfg_data_i;

  // Strict '>' while scanning upward keeps the lowest id on priority ties.
  always_comb begin
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (prio_q[3*i +: 3] > threshold_q);
      if (eligible[i] && (prio_q[3*i +: 3] > best_prio)) begin
        best_prio = prio_q[3*i +: 3];
        best_id   = 4'(i + 1);
      end
    end
  end

  assign interrupt_o     = |eligible;
  assign rise            = irq_i & ~prev_q;
  assign claim_id_o      = claim_id_q;
  assign cfg_read_data_o = rdata_q;

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    deferred_d   = deferred_q;
    enable_d     = enable_q;
    prio_d       = prio_q;
    threshold_d  = threshold_q;
    prev_d       = irq_i;
    claim_id_d   = claim_id_q;
    rdata_d      = '0;

    for (int i = 0; i < NUM_SOURCES; i++) begin
      // Gateway decisions use pre-edge pending/in_service, so a completing
      // source can only re-forward on the following cycle.
      if (!pending_q[i] && !in_service_q[i]) begin
        if (EDGE_MASK[i]) begin
          if (rise[i] || deferred_q[i]) begin
            pending_d[i]  = 1'b1;
            deferred_d[i] = 1'b0;
          end
        end else if (irq_i[i]) begin
          pending_d[i] = 1'b1;
        end
      end else if (EDGE_MASK[i] && rise[i]) begin
        deferred_d[i] = 1'b1;
      end

      if (complete_i && in_service_q[i] && (complete_id_i == 4'(i + 1))) begin
        in_service_d[i] = 1'b0;
      end
      if (claim_i && (best_id == 4'(i + 1))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
    end

    if (claim_i) begin
      claim_id_d = best_id;
    end

    if (cfg_write_enable_i) begin
      case (cfg_addr_i)
        2'd0:    enable_d    = cfg_data_i[NUM_SOURCES-1:0];
        2'd1:    threshold_d = cfg_data_i[2:0];
        2'd2:    prio_d      = cfg_data_i[PW-1:0];
        default: ;
      endcase
    end

    if (cfg_read_enable_i) begin
      case (cfg_addr_i)
        2'd0:    rdata_d = 32'(enable_q);
        2'd1:    rdata_d = 32'(threshold_q);
        2'd2:    rdata_d = 32'(prio_q);
        default: rdata_d = 32'(pending_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pending_q    <= '0;
      in_service_q <= '0;
      deferred_q   <= '0;
      enable_q     <= '0;
      prev_q       <= '0;
      prio_q       <= '0;
      threshold_q  <= '0;
      claim_id_q   <= '0;
      rdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      deferred_q   <= deferred_d;
      enable_q     <= enable_d;
      prev_q       <= prev_d;
      prio_q       <= prio_d;
      threshold_q  <= threshold_d;
      claim_id_q   <= claim_id_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_irq_arbiter.sv
// Bench for cpu_irq_arbiter: directed scenarios plus randomized traffic
// against a rule-level reference model. Ids 1 and 5 are edge-triggered.
module tb_cpu_irq_arbiter;

  localparam int             N    = 8;
  localparam logic [N-1:0]   EDGE = 8'h11;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b1;
  logic [N-1:0]  irq_i = '0;
  logic          claim_i = 1'b0;
  logic [3:0]    claim_id_o;
  logic          complete_i = 1'b0;
  logic [3:0]    complete_id_i = '0;
  logic          cfg_write_enable_i = 1'b0;
  logic [1:0]    cfg_addr_i = '0;
  logic [31:0]   cfg_data_i = '0;
  logic          cfg_read_enable_i = 1'b0;
  logic [31:0]   cfg_read_data_o;
  logic          interrupt_o;

  int checks = 0;
  int failures = 0;

  // Reference model state, ids 1..N
  bit [N:1] m_pend, m_insvc, m_def, m_en, m_prev;
  int       m_prio [1:N];
  int       m_thr;
  int       m_claim;
  logic [31:0] m_rdata;

  cpu_irq_arbiter #(.NUM_SOURCES(N), .EDGE_MASK(EDGE)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .irq_i(irq_i), .claim_i(claim_i),
    .claim_id_o(claim_id_o), .complete_i(complete_i), .complete_id_i(complete_id_i),
    .cfg_write_enable_i(cfg_write_enable_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_read_enable_i(cfg_read_enable_i),
    .cfg_read_data_o(cfg_read_data_o), .interrupt_o(interrupt_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_insvc = '0; m_def = '0; m_en = '0; m_prev = '0;
    for (int id = 1; id <= N; id++) m_prio[id] = 0;
    m_thr = 0; m_claim = 0; m_rdata = '0;
  endtask

  // Highest priority first, then lowest id; only priorities above threshold count.
  function automatic int model_best();
    for (int p = 7; p > m_thr; p--)
      for (int id = 1; id <= N; id++)
        if (m_pend[id] && m_en[id] && m_prio[id] == p) return id;
    return 0;
  endfunction

  // Advance one clock: evaluate the rules on the current inputs, then commit.
  task automatic tick();
    bit [N:1] n_pend, n_insvc, n_def, n_en;
    int n_prio [1:N];
    int n_thr, n_claim, best, cid;
    logic [31:0] n_rd;
    bit rise, busy;
    n_pend = m_pend; n_insvc = m_insvc; n_def = m_def; n_en = m_en;
    n_prio = m_prio; n_thr = m_thr; n_claim = m_claim; n_rd = '0;
    best = model_best();
    for (int id = 1; id <= N; id++) begin
      rise = irq_i[id-1] && !m_prev[id];
      busy = m_pend[id] || m_insvc[id];
      if (EDGE[id-1]) begin
        if (!busy && (rise || m_def[id])) begin n_pend[id] = 1; n_def[id] = 0; end
        else if (busy && rise) n_def[id] = 1;
      end else if (!busy && irq_i[id-1]) n_pend[id] = 1;
    end
    cid = int'(complete_id_i);
    if (complete_i && cid >= 1 && cid <= N && m_insvc[cid]) n_insvc[cid] = 0;
    if (claim_i) begin
      n_claim = best;
      if (best != 0) begin n_pend[best] = 0; n_insvc[best] = 1; end
    end
    if (cfg_write_enable_i) begin
      if (cfg_addr_i == 0) n_en = cfg_data_i[N-1:0];
      if (cfg_addr_i == 1) n_thr = int'(cfg_data_i[2:0]);
      if (cfg_addr_i == 2) for (int id = 1; id <= N; id++) n_prio[id] = int'((cfg_data_i >> (3*(id-1))) & 32'd7);
    end
    if (cfg_read_enable_i) begin
      case (cfg_addr_i)
        2'd0: n_rd = 32'(m_en);
        2'd1: n_rd = 32'(m_thr);
        2'd2: for (int id = 1; id <= N; id++) n_rd = n_rd | (32'(m_prio[id]) << (3*(id-1)));
        default: n_rd = 32'(m_pend);
      endcase
    end
    @(posedge clk); #1;
    m_pend = n_pend; m_insvc = n_insvc; m_def = n_def; m_en = n_en;
    m_prio = n_prio; m_thr = n_thr; m_claim = n_claim; m_rdata = n_rd;
    m_prev = irq_i;
  endtask

  task automatic apply_reset();
    reset_ni = 1'b0; model_reset();
    @(posedge clk); #1;
    reset_ni = 1'b1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_write_enable_i = 1; cfg_addr_i = a; cfg_data_i = d;
    tick();
    cfg_write_enable_i = 0; cfg_data_i = '0;
  endtask

  task automatic cfg_rd(input logic [1:0] a);
    cfg_read_enable_i = 1; cfg_addr_i = a;
    tick();
    cfg_read_enable_i = 0;
  endtask

  task automatic do_claim();
    claim_i = 1; tick(); claim_i = 0;
  endtask

  task automatic do_complete(input logic [3:0] id);
    complete_i = 1; complete_id_i = id; tick(); complete_i = 0; complete_id_i = '0;
  endtask

  task automatic test_reset();
    #1 reset_ni = 1'b0; model_reset();
    #1;
    checks++; if (claim_id_o !== 4'd0) begin failures++; $display("FAIL reset_claim got=%0d want=0", claim_id_o); end
    checks++; if (cfg_read_data_o !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%0h want=0", cfg_read_data_o); end
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", interrupt_o); end
    @(posedge clk); #1;
    reset_ni = 1'b1;
  endtask

  task automatic test_priority_tie();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, (32'd5 << 6) | (32'd5 << 15)); cfg_wr(1, 32'd2);
    irq_i = 8'h24; tick(); irq_i = '0;
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL tie_irq got=%b want=1", interrupt_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd3) begin failures++; $display("FAIL tie_claim1 got=%0d want=3", claim_id_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd6) begin failures++; $display("FAIL tie_claim2 got=%0d want=6", claim_id_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd0) begin failures++; $display("FAIL tie_claim3 got=%0d want=0", claim_id_o); end
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL tie_irq_end got=%b want=0", interrupt_o); end
  endtask

  task automatic test_threshold();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, 32'd2 << 3); cfg_wr(1, 32'd2);
    irq_i = 8'h02; tick(); tick();
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL thr_equal got=%b want=0", interrupt_o); end
    cfg_rd(3);
    checks++; if (cfg_read_data_o !== 32'h02) begin failures++; $display("FAIL thr_pending got=%0h want=2", cfg_read_data_o); end
    cfg_wr(1, 32'd1);
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL thr_lowered got=%b want=1", interrupt_o); end
    irq_i = '0;
  endtask

  task automatic test_edge_deferred();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, 32'd1); cfg_wr(1, 32'd0);
    irq_i = 8'h01; tick(); irq_i = '0; tick();
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL edge_irq got=%b want=1", interrupt_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd1) begin failures++; $display("FAIL edge_claim1 got=%0d want=1", claim_id_o); end
    for (int k = 0; k < 2; k++) begin irq_i = 8'h01; tick(); irq_i = '0; tick(); end
    cfg_rd(3);
    checks++; if (cfg_read_data_o !== 32'h0) begin failures++; $display("FAIL edge_pend_insvc got=%0h want=0", cfg_read_data_o); end
    do_complete(4'd1);
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL edge_at_complete got=%b want=0", interrupt_o); end
    tick();
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL edge_deferred_fwd got=%b want=1", interrupt_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd1) begin failures++; $display("FAIL edge_claim2 got=%0d want=1", claim_id_o); end
    do_complete(4'd1); tick(); tick();
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL edge_no_third got=%b want=0", interrupt_o); end
  endtask

  task automatic test_level_recomplete();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, 32'd3 << 9); cfg_wr(1, 32'd0);
    irq_i = 8'h08; tick();
    do_claim();
    checks++; if (claim_id_o !== 4'd4) begin failures++; $display("FAIL lvl_claim1 got=%0d want=4", claim_id_o); end
    do_complete(4'd4);
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL lvl_at_complete got=%b want=0", interrupt_o); end
    tick();
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL lvl_rerequest got=%b want=1", interrupt_o); end
    irq_i = '0;
    do_claim();
    checks++; if (claim_id_o !== 4'd4) begin failures++; $display("FAIL lvl_claim2 got=%0d want=4", claim_id_o); end
    do_complete(4'd4); tick();
    cfg_rd(3);
    checks++; if (cfg_read_data_o !== 32'h0 || interrupt_o !== 1'b0) begin failures++; $display("FAIL lvl_dropped got=%0h/%b want=0/0", cfg_read_data_o, interrupt_o); end
  endtask

  task automatic test_reset_mid_service();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, (32'd4 << 3) | (32'd3 << 12)); cfg_wr(1, 32'd0);
    irq_i = 8'h02; tick(); irq_i = '0;
    do_claim();
    checks++; if (claim_id_o !== 4'd2) begin failures++; $display("FAIL mid_claim got=%0d want=2", claim_id_o); end
    irq_i = 8'h10; tick(); irq_i = '0;
    cfg_rd(3);
    checks++; if (cfg_read_data_o !== 32'h10) begin failures++; $display("FAIL mid_pending got=%0h want=10", cfg_read_data_o); end
    #3 reset_ni = 1'b0; model_reset();
    #1;
    checks++; if (claim_id_o !== 4'd0 || interrupt_o !== 1'b0 || cfg_read_data_o !== 32'd0)
      begin failures++; $display("FAIL mid_async got=%0d/%b/%0h want=0/0/0", claim_id_o, interrupt_o, cfg_read_data_o); end
    @(posedge clk); #1;
    reset_ni = 1'b1;
    do_complete(4'd2);
    cfg_rd(3);
    checks++; if (cfg_read_data_o !== 32'h0) begin failures++; $display("FAIL mid_after_pending got=%0h want=0", cfg_read_data_o); end
    cfg_rd(0);
    checks++; if (cfg_read_data_o !== 32'h0) begin failures++; $display("FAIL mid_after_enable got=%0h want=0", cfg_read_data_o); end
  endtask

  task automatic test_claim_complete_same();
    apply_reset();
    cfg_wr(0, 32'hFF); cfg_wr(2, (32'd6 << 18) | (32'd2 << 6)); cfg_wr(1, 32'd0);
    irq_i = 8'h40; tick(); irq_i = '0;
    do_claim();
    checks++; if (claim_id_o !== 4'd7) begin failures++; $display("FAIL same_claim7 got=%0d want=7", claim_id_o); end
    irq_i = 8'h44; tick();
    claim_i = 1; complete_i = 1; complete_id_i = 4'd7; tick();
    claim_i = 0; complete_i = 0; complete_id_i = '0;
    checks++; if (claim_id_o !== 4'd3) begin failures++; $display("FAIL same_other got=%0d want=3", claim_id_o); end
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL same_not_yet got=%b want=0", interrupt_o); end
    tick();
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL same_unblocked got=%b want=1", interrupt_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd7) begin failures++; $display("FAIL same_reclaim got=%0d want=7", claim_id_o); end
    irq_i = '0;
  endtask

  task automatic test_release_edge();
    irq_i = 8'h01;
    apply_reset();
    tick();
    cfg_wr(0, 32'hFF); cfg_wr(2, 32'd1);
    checks++; if (interrupt_o !== 1'b1) begin failures++; $display("FAIL rel_edge_fwd got=%b want=1", interrupt_o); end
    do_claim();
    checks++; if (claim_id_o !== 4'd1) begin failures++; $display("FAIL rel_edge_claim got=%0d want=1", claim_id_o); end
    do_complete(4'd1); tick(); tick();
    checks++; if (interrupt_o !== 1'b0) begin failures++; $display("FAIL rel_edge_once got=%b want=0", interrupt_o); end
    irq_i = '0;
  endtask

  task automatic test_random();
    int exp_irq;
    apply_reset();
    cfg_wr(0, 32'hFF);
    for (int c = 0; c < 2500; c++) begin
      irq_i              = N'($urandom & $urandom);
      claim_i            = ($urandom_range(0, 3) == 0);
      complete_i         = ($urandom_range(0, 2) == 0);
      complete_id_i      = 4'($urandom_range(0, 15));
      cfg_write_enable_i = ($urandom_range(0, 11) == 0);
      cfg_addr_i         = 2'($urandom_range(0, 3));
      cfg_data_i         = (cfg_addr_i == 2'd1) ? 32'($urandom_range(0, 3)) : $urandom;
      cfg_read_enable_i  = ($urandom_range(0, 2) == 0);
      tick();
      exp_irq = (model_best() != 0) ? 1 : 0;
      checks++; if (claim_id_o !== 4'(m_claim)) begin failures++; $display("FAIL rnd_claim c=%0d got=%0d want=%0d", c, claim_id_o, m_claim); end
      checks++; if (interrupt_o !== 1'(exp_irq)) begin failures++; $display("FAIL rnd_irq c=%0d got=%b want=%0d", c, interrupt_o, exp_irq); end
      checks++; if (cfg_read_data_o !== m_rdata) begin failures++; $display("FAIL rnd_rdata c=%0d got=%0h want=%0h", c, cfg_read_data_o, m_rdata); end
    end
    irq_i = '0; claim_i = 0; complete_i = 0; cfg_write_enable_i = 0; cfg_read_enable_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority_tie();
    test_threshold();
    test_edge_deferred();
    test_level_recomplete();
    test_reset_mid_service();
    test_claim_complete_same();
    test_release_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
